// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : PC owner and request/acknowledge fetch front end with a one-entry
//            skid register, stall support and redirect/flush handling.
// Revision : 1.0
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Data,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    output logic [31:0] Instruction,
    output logic [31:0] PC_Next,
    output logic        Fetch_Valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic [31:0] r_pend_pc;
    logic        r_req;
    logic [31:0] r_instr;
    logic [31:0] r_pc_next;
    logic        r_valid;

    logic        w_slot_free;
    logic [31:0] w_pc_inc;
    logic [31:0] w_target;
    logic        w_unused_lsb;

    assign w_slot_free  = !r_valid || !Stall;
    assign w_pc_inc     = r_pc + 32'd4;
    assign w_target     = {Redirect_PC[31:2], 2'b00};
    assign w_unused_lsb = ^Redirect_PC[1:0];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= 32'd0;
            r_pend_pc    <= RESET_PC;
            r_req        <= 1'b0;
            r_instr      <= NOP_INSTR;
            r_pc_next    <= 32'd0;
            r_valid      <= 1'b0;
        end else if (Redirect) begin
            r_instr   <= NOP_INSTR;
            r_pc_next <= 32'd0;
            r_valid   <= 1'b0;
            // An unanswered request must stay up at its old address until it drains
            if ((r_state == S_WAIT || r_state == S_DRAIN) && !IMem_Ack) begin
                r_pend_pc <= w_target;
                r_state   <= S_DRAIN;
            end else begin
                r_pc       <= w_target;
                r_req_addr <= w_target;
                r_req      <= 1'b1;
                r_state    <= S_WAIT;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_addr <= r_pc;
                    r_req      <= 1'b1;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (IMem_Ack) begin
                        r_pc <= w_pc_inc;
                        if (w_slot_free) begin
                            r_instr    <= IMem_Data;
                            r_pc_next  <= w_pc_inc;
                            r_valid    <= 1'b1;
                            r_req_addr <= w_pc_inc;
                        end else begin
                            r_skid_instr <= IMem_Data;
                            r_skid_pc    <= w_pc_inc;
                            r_req        <= 1'b0;
                            r_state      <= S_HOLD;
                        end
                    end else if (!Stall) begin
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!Stall) begin
                        r_instr    <= r_skid_instr;
                        r_pc_next  <= r_skid_pc;
                        r_valid    <= 1'b1;
                        r_req_addr <= r_pc;
                        r_req      <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                end
                S_DRAIN: begin
                    // Response to the abandoned address is dropped on the floor
                    if (IMem_Ack) begin
                        r_pc       <= r_pend_pc;
                        r_req_addr <= r_pend_pc;
                        r_state    <= S_WAIT;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign IMem_Req    = r_req;
    assign IMem_Addr   = r_req_addr;
    assign Instruction = r_instr;
    assign PC_Next     = r_pc_next;
    assign Fetch_Valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Brief    : Directed and randomized self-checking bench for the fetch unit.
// Revision : 1.0
// ============================================================================
module tb_instruction_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        Clk;
    logic        Rst;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ack;
    logic [31:0] IMem_Data;
    logic        Stall;
    logic        Redirect;
    logic [31:0] Redirect_PC;
    logic [31:0] Instruction;
    logic [31:0] PC_Next;
    logic        Fetch_Valid;

    logic        auto_mode;
    logic        ack_man;
    logic [31:0] data_man;

    int errors = 0;
    int checks = 0;

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .IMem_Req    (IMem_Req),
        .IMem_Addr   (IMem_Addr),
        .IMem_Ack    (IMem_Ack),
        .IMem_Data   (IMem_Data),
        .Stall       (Stall),
        .Redirect    (Redirect),
        .Redirect_PC (Redirect_PC),
        .Instruction (Instruction),
        .PC_Next     (PC_Next),
        .Fetch_Valid (Fetch_Valid)
    );

    // Zero-wait memory answers every request with addr ^ KEY
    assign IMem_Ack  = auto_mode ? IMem_Req : ack_man;
    assign IMem_Data = auto_mode ? (IMem_Addr ^ KEY) : data_man;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Program-order reference: each consumed word must be the next sequential
    // fetch address (or the redirect target), with data = addr ^ KEY.
    logic [31:0] exp_pc;
    logic        prev_req, prev_ack, prev_redir;
    logic [31:0] prev_addr;
    logic        s_stall, s_redir, s_ack;
    logic [31:0] s_tgt;
    int          consumed;

    initial begin
        Rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; Redirect_PC = 32'd0;
        auto_mode = 1'b0; ack_man = 1'b0; data_man = 32'd0;

        @(negedge Clk);
        chk("rst_req",   IMem_Req,    32'd0);
        chk("rst_addr",  IMem_Addr,   32'd0);
        chk("rst_instr", Instruction, 32'd0);
        chk("rst_pcn",   PC_Next,     32'd0);
        chk("rst_valid", Fetch_Valid, 32'd0);
        auto_mode = 1'b1; Rst = 1'b0;

        @(negedge Clk);
        chk("first_req",  IMem_Req,    32'd1);
        chk("first_addr", IMem_Addr,   32'd0);
        chk("idle_valid", Fetch_Valid, 32'd0);

        @(negedge Clk);
        chk("zw_instr0", Instruction, 32'hA5A5_A5A5);
        chk("zw_pcn0",   PC_Next,     32'd4);
        chk("zw_valid0", Fetch_Valid, 32'd1);
        chk("zw_addr4",  IMem_Addr,   32'd4);

        @(negedge Clk);
        chk("zw_addr8",  IMem_Addr,   32'd8);
        chk("zw_instr1", Instruction, 32'd4 ^ KEY);
        chk("zw_pcn1",   PC_Next,     32'd8);

        // Ack at addr 8 while stalled -> skid/HOLD
        auto_mode = 1'b0; ack_man = 1'b1; data_man = 32'h1111_1111; Stall = 1'b1;
        @(negedge Clk);
        chk("hold_req",   IMem_Req,    32'd0);
        chk("hold_instr", Instruction, 32'd4 ^ KEY);
        chk("hold_pcn",   PC_Next,     32'd8);
        chk("hold_valid", Fetch_Valid, 32'd1);
        ack_man = 1'b0; data_man = $urandom;
        @(negedge Clk);
        chk("hold2_req",   IMem_Req,    32'd0);
        chk("hold2_instr", Instruction, 32'd4 ^ KEY);
        Stall = 1'b0;
        @(negedge Clk);
        chk("unskid_instr", Instruction, 32'h1111_1111);
        chk("unskid_pcn",   PC_Next,     32'h0000_000C);
        chk("unskid_req",   IMem_Req,    32'd1);
        chk("unskid_addr",  IMem_Addr,   32'h0000_000C);

        // Redirect coincident with an Ack
        ack_man = 1'b1; data_man = 32'hDEAD_BEEF; Redirect = 1'b1; Redirect_PC = 32'h100;
        @(negedge Clk);
        chk("redir_valid", Fetch_Valid, 32'd0);
        chk("redir_instr", Instruction, 32'd0);
        chk("redir_pcn",   PC_Next,     32'd0);
        chk("redir_addr",  IMem_Addr,   32'h100);
        chk("redir_req",   IMem_Req,    32'd1);

        // Redirect during the first wait cycle of a 3-cycle-latency fetch
        ack_man = 1'b0; Redirect_PC = 32'h200;
        @(negedge Clk);
        chk("drain_req",   IMem_Req,    32'd1);
        chk("drain_addr",  IMem_Addr,   32'h100);
        chk("drain_valid", Fetch_Valid, 32'd0);
        Redirect = 1'b0;
        @(negedge Clk);
        chk("drain2_req",  IMem_Req,  32'd1);
        chk("drain2_addr", IMem_Addr, 32'h100);
        ack_man = 1'b1; data_man = 32'hBAD0_BAD0;
        @(negedge Clk);
        chk("tgt_addr",  IMem_Addr,   32'h200);
        chk("tgt_req",   IMem_Req,    32'd1);
        chk("tgt_valid", Fetch_Valid, 32'd0);
        data_man = 32'h1234_5678;
        @(negedge Clk);
        chk("tgt_instr", Instruction, 32'h1234_5678);
        chk("tgt_pcn",   PC_Next,     32'h204);
        chk("tgt_valid1", Fetch_Valid, 32'd1);

        // Unaligned redirect near the top of the address space
        Redirect = 1'b1; Redirect_PC = 32'hFFFF_FFFE; data_man = $urandom;
        @(negedge Clk);
        chk("wrap_addr",  IMem_Addr,   32'hFFFF_FFFC);
        chk("wrap_valid", Fetch_Valid, 32'd0);
        Redirect = 1'b0; data_man = 32'hCAFE_F00D;
        @(negedge Clk);
        chk("wrap_instr", Instruction, 32'hCAFE_F00D);
        chk("wrap_pcn",   PC_Next,     32'd0);
        chk("wrap_valid1", Fetch_Valid, 32'd1);
        chk("wrap_next",  IMem_Addr,   32'd0);

        // Enter HOLD, then hit reset asynchronously mid-cycle
        Stall = 1'b1; data_man = 32'h55AA_55AA;
        @(negedge Clk);
        chk("h2_req",   IMem_Req,    32'd0);
        chk("h2_instr", Instruction, 32'hCAFE_F00D);
        ack_man = 1'b0;
        #2 Rst = 1'b1;
        #1;
        chk("arst_req",   IMem_Req,    32'd0);
        chk("arst_addr",  IMem_Addr,   32'd0);
        chk("arst_instr", Instruction, 32'd0);
        chk("arst_pcn",   PC_Next,     32'd0);
        chk("arst_valid", Fetch_Valid, 32'd0);
        @(negedge Clk);
        Rst = 1'b0; Stall = 1'b0;
        @(negedge Clk);
        chk("restart_req",  IMem_Req,  32'd1);
        chk("restart_addr", IMem_Addr, 32'd0);

        // Randomized phase against the program-order model
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        exp_pc = 32'd0; prev_req = 1'b0; prev_ack = 1'b0; prev_redir = 1'b0;
        prev_addr = 32'd0; consumed = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge Clk);
            chk("rnd_align", {30'd0, IMem_Addr[1:0]}, 32'd0);
            if (prev_req && !prev_ack) begin
                chk("rnd_req_hold",  IMem_Req,  32'd1);
                chk("rnd_addr_hold", IMem_Addr, prev_addr);
            end
            if (prev_redir) begin
                chk("rnd_flush_valid", Fetch_Valid, 32'd0);
                chk("rnd_flush_instr", Instruction, 32'd0);
                chk("rnd_flush_pcn",   PC_Next,     32'd0);
            end
            s_stall = ($urandom_range(0, 2) == 0);
            s_redir = ($urandom_range(0, 15) == 0);
            s_tgt   = $urandom;
            s_ack   = IMem_Req && ($urandom_range(0, 1) == 1);
            Stall       = s_stall;
            Redirect    = s_redir;
            Redirect_PC = s_tgt;
            ack_man     = s_ack;
            data_man    = s_ack ? (IMem_Addr ^ KEY) : $urandom;
            if (s_redir) begin
                exp_pc = s_tgt & 32'hFFFF_FFFC;
            end else if (Fetch_Valid && !s_stall) begin
                chk("rnd_instr", Instruction, exp_pc ^ KEY);
                chk("rnd_pcn",   PC_Next,     exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            prev_req   = IMem_Req;
            prev_ack   = s_ack;
            prev_addr  = IMem_Addr;
            prev_redir = s_redir;
        end
        chk("rnd_progress", {31'd0, (consumed >= 100)}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front end of the pipeline: owns the program counter, runs a request/acknowledge handshake with instruction memory, and produces the Instruction / PC_Next pair that the IF/ID buffer captures on every rising edge. Honours a hazard stall from the ID stage via a one-entry skid register. Honours a branch/jump redirect that flushes the fetched word and discards any in-flight memory response.

## Interface
- RESET_PC, 32'h00000000, first fetch address after reset.
- NOP_INSTR, 32'h00000000, word driven on Instruction when no valid fetch is present.

- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-high reset.
- IMem_Req  out  1  fetch request; held high with stable IMem_Addr until IMem_Ack.
- IMem_Addr  out  32  word-aligned fetch address; bits [1:0] always 00.
- IMem_Ack  in  1  response strobe; IMem_Data valid in the same cycle; only legal while IMem_Req=1.
- IMem_Data  in  32  fetched instruction word.
- Stall  in  1  ID hazard; when 1, the ID stage does not consume the current output.
- Redirect  in  1  branch/jump taken; flush and refetch.
- Redirect_PC  in  32  target address; bits [1:0] ignored.
- Instruction  out  32  fetched word, registered.
- PC_Next  out  32  fetch address of Instruction + 4, registered.
- Fetch_Valid  out  1  Instruction/PC_Next hold a real fetch.

## Operation
- Registers: PC (next fetch address), req_addr, skid_instr, skid_pc, pend_pc, output slot (Instruction, PC_Next, Fetch_Valid).
- The output slot is consumed at any edge where Stall=0. It is free if Fetch_Valid=0 or it is consumed at that edge.
- IMem_Req is 1 in WAIT and DRAIN and 0 otherwise. IMem_Addr = req_addr. req_addr is loaded from PC on every entry to WAIT and after every accepted response in WAIT.
- States:
  - IDLE: reset state; always goes to WAIT.
  - WAIT: a request is outstanding at PC.
    - Ack with slot free: load the slot with IMem_Data and PC+4, set Fetch_Valid=1, set PC=PC+4, stay in WAIT.
    - Ack with slot not free: load the skid register with the word and PC+4, set PC=PC+4, go to HOLD.
    - No Ack and slot consumed: Fetch_Valid=0, Instruction=NOP_INSTR.
  - HOLD: skid full, no request.
    - Stall=0: move the skid contents into the slot and go to WAIT.
    - Stall=1: hold everything.
  - DRAIN: a redirected request is still outstanding at the old address. Ack is discarded, then PC=pend_pc and go to WAIT.
- Redirect has top priority after Rst and overrides Stall:
  - The slot becomes NOP_INSTR/0/0 and the skid is dropped.
  - WAIT without Ack: pend_pc=Redirect_PC, go to DRAIN, keep Req high with the old address.
  - WAIT with Ack, IDLE or HOLD: PC=Redirect_PC, go to WAIT; a response arriving that cycle is discarded.
  - DRAIN: pend_pc=Redirect_PC. If Ack arrives the same cycle, PC=Redirect_PC and go to WAIT.
- Arithmetic: PC+4 is 32-bit modulo (0xFFFFFFFC+4 = 0x00000000). Redirect_PC is forced to {Redirect_PC[31:2],2'b00}.

## Timing
- Reset values, forced asynchronously:
  - state = IDLE, PC = RESET_PC, req_addr = RESET_PC.
  - IMem_Req = 0, Instruction = NOP_INSTR, PC_Next = 0, Fetch_Valid = 0, skid empty.
- First IMem_Req=1 occurs on the first cycle after the first edge following Rst deassertion.
- Latency: Ack in cycle n puts the word on Instruction in cycle n+1.
- With zero-wait memory (Ack tied to Req), throughput is one instruction per cycle and the address advances by 4 every cycle.
- Redirect at edge n: the slot is NOP from cycle n+1. The first target word appears at (target Ack cycle)+1.
- Reset mid-operation: any outstanding request is abandoned. The memory must tolerate Req dropping on Rst.

## Test plan
- Reset release with zero-wait memory returning data=addr^0xA5A5A5A5 -> IMem_Addr 0,4,8,…; Instruction=0xA5A5A5A5 with PC_Next=4 one cycle after the first Ack; Fetch_Valid=0 during IDLE.
- Stall=1 while Fetch_Valid=1 and Ack returns word 0x11111111 at addr 8 -> HOLD: IMem_Req=0, outputs frozen. Stall=0 -> next cycle Instruction=0x11111111, PC_Next=0xC, Req=1 at addr 0xC.
- Redirect to 0x100 in the same cycle as an Ack -> next cycle Fetch_Valid=0, Instruction=NOP; IMem_Addr=0x100. The acked word never appears.
- Memory with 3-cycle latency, Redirect to 0x200 in the first wait cycle -> Req stays high at the old address until Ack; that data is discarded; then IMem_Addr=0x200.
- Redirect to 0xFFFFFFFE -> fetch at 0xFFFFFFFC, PC_Next=0x00000000, next IMem_Addr=0x00000000.
- Rst pulse asserted mid-cycle while in HOLD with Stall=1 -> all outputs reset immediately without a clock edge; restart from RESET_PC.
